matrix_tx_formatter: RTL and testbench
======================================

MATRIX_TX_FORMATTER -- requirements
Module: matrix_tx_formatter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, the UART bit time in clk cycles (100 MHz / 115200 baud).
REQ-002 SHALL have parameter MAX_DIM, default 5, the largest legal row or column count.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_start  in  1  single-cycle request to dump one matrix.
REQ-006 i_base_addr  in  8  storage address of element (0,0).
REQ-007 i_dim_m  in  32  row count.
REQ-008 i_dim_n  in  32  column count.
REQ-009 o_rd_addr  out  8  storage read address.
REQ-010 i_rd_data  in  32  storage read data, valid exactly 1 cycle after o_rd_addr.
REQ-011 o_uart_tx  out  1  serial line; idles high.
REQ-012 o_busy  out  1  high from i_start acceptance until o_done.
REQ-013 o_done  out  1  one-cycle pulse at the end of a dump.
REQ-014 o_err  out  1  one-cycle pulse, coincident with o_done, on illegal dimensions.

Function
REQ-015 Inputs SHALL be sampled on the cycle i_start is high and o_busy is low; i_start while busy SHALL be ignored.
REQ-016 Elements SHALL be read row-major; element (r,c) is at i_base_addr + r*n + c, with 8-bit wrap.
REQ-017 Elements SHALL be converted from i_rd_data[15:0] to ASCII decimal.
  - Conversion uses successive subtraction of 10000, 1000, 100, 10 and 1.
  - Leading zeros are suppressed; the value 0 SHALL be emitted as "0".
REQ-018 Each element SHALL be followed by 0x20; the last element of each row SHALL additionally be followed by 0x0D then 0x0A.
REQ-019 Each byte SHALL be framed as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each bit lasting CLKS_PER_BIT cycles.
  - The next byte's start bit SHALL begin immediately after the stop bit (no idle gap).
REQ-020 The control FSM states SHALL be IDLE, FETCH, WAIT_RD, CONVERT, SEND_DIGIT, SEND_SEP, SEND_CR, SEND_LF and DONE.
  - IDLE->FETCH on accepted start.
  - FETCH->WAIT_RD->CONVERT.
  - CONVERT->SEND_DIGIT.
  - SEND_DIGIT->SEND_SEP after the last digit.
  - SEND_SEP->FETCH when the element is not at the end of its row; SEND_SEP->SEND_CR otherwise.
  - SEND_CR->SEND_LF.
  - SEND_LF->FETCH when more rows remain; SEND_LF->DONE otherwise.
  - DONE->IDLE.
REQ-021 The first start bit SHALL appear on o_uart_tx no later than 8 cycles after the accepted i_start.
REQ-022 o_done SHALL pulse in the cycle after the final stop bit completes; o_busy SHALL fall in the same cycle.
REQ-023 If m or n is 0 or greater than MAX_DIM, the block SHALL emit no bytes and pulse o_done and o_err 2 cycles after the accepted start.
REQ-024 o_rd_addr SHALL change only in FETCH and SHALL hold its value otherwise.

Reset
REQ-025 On rst_n low, regardless of the clock: o_uart_tx=1, o_busy=0, o_done=0, o_err=0, o_rd_addr=0, FSM=IDLE, and all counters cleared.
REQ-026 Reset mid-byte SHALL abort the dump; no partial byte SHALL resume after release.

Configuration
REQ-027 Macro MTX_SIGNED_EN.
  - Defined: bits [15:0] are two's complement; a negative value SHALL emit 0x2D ('-') followed by the magnitude digits.
  - Undefined: bits [15:0] are unsigned 0..65535 and no '-' is ever emitted.

Verification
REQ-028 1x1, data 7 -> bytes 0x37 0x20 0x0D 0x0A, then o_done; each bit is 8680 ns at 10 ns clk.
REQ-029 2x3 at base 0, data 1..6 -> "1 2 3 \r\n4 5 6 \r\n"; o_rd_addr sequence 0,1,2,3,4,5.
REQ-030 1x3, data 0, 12345, 100 -> "0 12345 100 \r\n".
REQ-031 1x1, data 0xFFF6 -> "-10 \r\n" with MTX_SIGNED_EN; "65526 \r\n" without.
REQ-032 Dimensions 0x3 or 6x1 -> no falling edge on o_uart_tx; o_done and o_err pulse together.
REQ-033 Two corner cases:
  - rst_n low during the third data bit -> o_uart_tx goes high immediately and o_busy=0.
  - i_start pulsed while busy -> the output stream is unchanged.

Source files
------------

// File: rtl/matrix_tx_formatter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : matrix_tx_formatter                                          |
// | Description : Reads an m x n matrix row-major from a synchronous storage   |
// |               port and prints it as ASCII decimal text over a UART 8N1     |
// |               line. Each element is followed by a space, and each row ends |
// |               with CR LF. Bytes go out back to back with no idle gap.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   CLKS_PER_BIT : UART bit time in clk cycles                               |
// |   MAX_DIM      : largest legal row / column count                          |
// | Ports                                                                      |
// |   clk          in   system clock, rising edge                              |
// |   rst_n        in   asynchronous active-low reset                          |
// |   i_start      in   single-cycle dump request (ignored while busy)         |
// |   i_base_addr  in   8-bit address of element (0,0)                         |
// |   i_dim_m      in   row count                                              |
// |   i_dim_n      in   column count                                           |
// |   o_rd_addr    out  storage read address                                   |
// |   i_rd_data    in   storage read data, valid 1 cycle after o_rd_addr       |
// |   o_uart_tx    out  serial line, idles high                                |
// |   o_busy       out  high while a dump is in progress                       |
// |   o_done       out  one-cycle pulse at the end of a dump                   |
// |   o_err        out  one-cycle pulse with o_done on illegal dimensions      |
// | Build option                                                               |
// |   MTX_SIGNED_EN : when defined, i_rd_data[15:0] is two's complement and   |
// |                   negative values are printed with a leading '-'.         |
// +----------------------------------------------------------------------------+
module matrix_tx_formatter #(
   parameter int CLKS_PER_BIT = 868,
   parameter int MAX_DIM      = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [7:0]  i_base_addr,
   input  logic [31:0] i_dim_m,
   input  logic [31:0] i_dim_n,
   output logic [7:0]  o_rd_addr,
   input  logic [31:0] i_rd_data,
   output logic        o_uart_tx,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);

   localparam int DW = (MAX_DIM < 2) ? 1 : $clog2(MAX_DIM + 1);
   localparam int BW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      FETCH      = 4'd1,
      WAIT_RD    = 4'd2,
      CONVERT    = 4'd3,
      SEND_DIGIT = 4'd4,
      SEND_SEP   = 4'd5,
      SEND_CR    = 4'd6,
      SEND_LF    = 4'd7,
      DONE       = 4'd8
   } state_t;

   state_t        state;
   logic [DW-1:0] row;
   logic [DW-1:0] col;
   logic [DW-1:0] m_last;
   logic [DW-1:0] n_last;
   logic [7:0]    elem_addr;
   logic [15:0]   value;
   logic          neg_pend;
   logic [2:0]    place;
   logic          err_flag;

   // serializer
   logic          tx_active;
   logic [3:0]    tx_bit;
   logic [BW-1:0] tx_baud;
   logic [9:0]    tx_shift;

   logic          tx_last;
   logic          tx_ready;
   logic          tx_load;
   logic [7:0]    tx_byte;
   logic          dims_bad;
   logic          rd_neg;
   logic [15:0]   rd_mag;
   logic [2:0]    lead_place;
   logic [15:0]   weight;
   logic [15:0]   rem_val;
   logic [3:0]    digit;

   // upper storage bits carry no information for this block
   logic          unused_rd_hi;
   assign unused_rd_hi = ^i_rd_data[31:16];

   assign dims_bad = (i_dim_m == 32'd0) || (i_dim_m > 32'(MAX_DIM)) ||
                     (i_dim_n == 32'd0) || (i_dim_n > 32'(MAX_DIM));

   // The serializer can take a new byte while idle or during the final cycle
   // of a stop bit, which lets consecutive frames abut with no idle gap.
   assign tx_last  = tx_active && (tx_bit == 4'd9) && (tx_baud == BAUD_LAST);
   assign tx_ready = !tx_active || tx_last;

   // Magnitude and sign of the freshly read element, plus the first decimal
   // place worth printing so that leading zeros never cost a cycle.
   always_comb begin
`ifdef MTX_SIGNED_EN
      rd_neg = i_rd_data[15];
      rd_mag = i_rd_data[15] ? (~i_rd_data[15:0] + 16'd1) : i_rd_data[15:0];
`else
      rd_neg = 1'b0;
      rd_mag = i_rd_data[15:0];
`endif
      if (rd_mag >= 16'd10000)     lead_place = 3'd0;
      else if (rd_mag >= 16'd1000) lead_place = 3'd1;
      else if (rd_mag >= 16'd100)  lead_place = 3'd2;
      else if (rd_mag >= 16'd10)   lead_place = 3'd3;
      else                         lead_place = 3'd4;
   end

   // Digit at the current place by successive subtraction of its weight.
   // The remainder is always below ten times the weight, except at the
   // 10000 place where 65535 bounds the count at six.
   always_comb begin
      case (place)
         3'd0:    weight = 16'd10000;
         3'd1:    weight = 16'd1000;
         3'd2:    weight = 16'd100;
         3'd3:    weight = 16'd10;
         default: weight = 16'd1;
      endcase
      rem_val = value;
      digit   = 4'd0;
      for (int k = 0; k < 9; k++) begin
         if (rem_val >= weight) begin
            rem_val = rem_val - weight;
            digit   = digit + 4'd1;
         end
      end
   end

   always_comb begin
      tx_byte = 8'h00;
      case (state)
         SEND_DIGIT: tx_byte = neg_pend ? 8'h2D : (8'h30 + {4'd0, digit});
         SEND_SEP:   tx_byte = 8'h20;
         SEND_CR:    tx_byte = 8'h0D;
         SEND_LF:    tx_byte = 8'h0A;
         default:    tx_byte = 8'h00;
      endcase
   end

   assign tx_load = tx_ready && ((state == SEND_DIGIT) || (state == SEND_SEP) ||
                                 (state == SEND_CR)    || (state == SEND_LF));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         row       <= '0;
         col       <= '0;
         m_last    <= '0;
         n_last    <= '0;
         elem_addr <= 8'd0;
         value     <= 16'd0;
         neg_pend  <= 1'b0;
         place     <= 3'd0;
         err_flag  <= 1'b0;
         tx_active <= 1'b0;
         tx_bit    <= 4'd0;
         tx_baud   <= '0;
         tx_shift  <= 10'h3FF;
         o_rd_addr <= 8'd0;
         o_uart_tx <= 1'b1;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         o_err  <= 1'b0;

         // bit timing of the frame in flight
         if (tx_active) begin
            if (tx_baud == BAUD_LAST) begin
               tx_baud <= '0;
               if (tx_bit == 4'd9) begin
                  tx_active <= 1'b0;
               end else begin
                  tx_bit    <= tx_bit + 4'd1;
                  o_uart_tx <= tx_shift[1];
                  tx_shift  <= {1'b1, tx_shift[9:1]};
               end
            end else begin
               tx_baud <= tx_baud + BW'(1);
            end
         end

         // a new frame overrides the stop-bit bookkeeping above
         if (tx_load) begin
            tx_shift  <= {1'b1, tx_byte, 1'b0};
            tx_active <= 1'b1;
            tx_bit    <= 4'd0;
            tx_baud   <= '0;
            o_uart_tx <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (i_start && !o_busy) begin
                  o_busy    <= 1'b1;
                  elem_addr <= i_base_addr;
                  row       <= '0;
                  col       <= '0;
                  m_last    <= DW'(i_dim_m - 32'd1);
                  n_last    <= DW'(i_dim_n - 32'd1);
                  err_flag  <= dims_bad;
                  state     <= dims_bad ? DONE : FETCH;
               end
            end
            FETCH: begin
               o_rd_addr <= elem_addr;
               state     <= WAIT_RD;
            end
            WAIT_RD: begin
               state <= CONVERT;
            end
            CONVERT: begin
               value    <= rd_mag;
               neg_pend <= rd_neg;
               place    <= lead_place;
               state    <= SEND_DIGIT;
            end
            SEND_DIGIT: begin
               if (tx_ready) begin
                  if (neg_pend) begin
                     neg_pend <= 1'b0;
                  end else begin
                     value <= rem_val;
                     if (place == 3'd4) state <= SEND_SEP;
                     else               place <= place + 3'd1;
                  end
               end
            end
            SEND_SEP: begin
               if (tx_ready) begin
                  if (col == n_last) begin
                     state <= SEND_CR;
                  end else begin
                     col       <= col + DW'(1);
                     elem_addr <= elem_addr + 8'd1;
                     state     <= FETCH;
                  end
               end
            end
            SEND_CR: begin
               if (tx_ready) state <= SEND_LF;
            end
            SEND_LF: begin
               if (tx_ready) begin
                  if (row == m_last) begin
                     state <= DONE;
                  end else begin
                     row       <= row + DW'(1);
                     col       <= '0;
                     elem_addr <= elem_addr + 8'd1;
                     state     <= FETCH;
                  end
               end
            end
            DONE: begin
               // finish once the last stop bit has fully elapsed
               if (!tx_active || tx_last) begin
                  o_done <= 1'b1;
                  o_err  <= err_flag;
                  o_busy <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_matrix_tx_formatter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_matrix_tx_formatter                                       |
// | Description : Directed self-checking bench for matrix_tx_formatter. A      |
// |               storage model answers reads one cycle late, a UART receiver |
// |               decodes the line, and each step compares against hand-      |
// |               computed text and timing.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_matrix_tx_formatter;

   localparam int CPB   = 16;
   localparam int MAXD  = 5;
   localparam int FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  i_base_addr = 8'd0;
   logic [31:0] i_dim_m = 32'd0;
   logic [31:0] i_dim_n = 32'd0;
   logic [7:0]  o_rd_addr;
   logic [31:0] i_rd_data = 32'd0;
   logic        o_uart_tx;
   logic        o_busy;
   logic        o_done;
   logic        o_err;

   matrix_tx_formatter #(
      .CLKS_PER_BIT (CPB),
      .MAX_DIM      (MAXD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_base_addr (i_base_addr),
      .i_dim_m     (i_dim_m),
      .i_dim_n     (i_dim_n),
      .o_rd_addr   (o_rd_addr),
      .i_rd_data   (i_rd_data),
      .o_uart_tx   (o_uart_tx),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_err       (o_err)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous storage model
   logic [31:0] mem [0:255];
   always @(posedge clk) i_rd_data <= mem[o_rd_addr];

   // line monitors
   logic [7:0] rx_q[$];
   int         rx_starts[$];
   int         frame_errs = 0;
   int         fall_cnt = 0;
   logic       prev_tx = 1'b1;
   logic [7:0] addr_q[$];
   logic [7:0] prev_addr = 8'd0;

   always @(negedge clk) begin
      if (prev_tx === 1'b1 && o_uart_tx === 1'b0) fall_cnt++;
      prev_tx = o_uart_tx;
      if (o_rd_addr !== prev_addr) begin
         addr_q.push_back(o_rd_addr);
         prev_addr = o_rd_addr;
      end
   end

   initial begin : rx_mon
      logic [7:0] b;
      logic       good;
      forever begin
         @(negedge clk);
         if (o_uart_tx === 1'b0) begin
            rx_starts.push_back(cyc);
            repeat (CPB / 2) @(negedge clk);
            good = (o_uart_tx === 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = o_uart_tx;
            end
            repeat (CPB) @(negedge clk);
            if (o_uart_tx !== 1'b1) good = 1'b0;
            rx_q.push_back(b);
            if (!good) frame_errs++;
            repeat (CPB - 1 - CPB / 2) @(negedge clk);
         end
      end
   end

   string CRLF;
   int    acc_cyc;
   int    dcyc;
   logic  derr;
   logic  dbusy;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic string q_hex();
      string s = "";
      foreach (rx_q[i]) s = {s, $sformatf("%02h ", rx_q[i])};
      return s;
   endfunction

   function automatic string s_hex(input string e);
      string s = "";
      for (int i = 0; i < e.len(); i++) s = {s, $sformatf("%02h ", e[i])};
      return s;
   endfunction

   task automatic check_stream(input string tag, input string exp);
      logic ok;
      ok = (rx_q.size() == exp.len());
      for (int i = 0; i < exp.len() && ok; i++)
         if (rx_q[i] !== exp[i]) ok = 1'b0;
      compared++;
      assert (ok) else begin
         mismatched++;
         $error("FAIL %s: observed [%s] expected [%s]", tag, q_hex(), s_hex(exp));
      end
   endtask

   function automatic logic spacing_ok();
      for (int i = 1; i < rx_starts.size(); i++)
         if (rx_starts[i] - rx_starts[i-1] != FRAME) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int last_start();
      return (rx_starts.size() > 0) ? rx_starts[rx_starts.size()-1] : -100000;
   endfunction

   task automatic clear_mon();
      rx_q.delete();
      rx_starts.delete();
      addr_q.delete();
      frame_errs = 0;
   endtask

   task automatic pulse_start(input logic [7:0] base, input logic [31:0] m, input logic [31:0] n);
      @(negedge clk);
      i_base_addr = base;
      i_dim_m     = m;
      i_dim_n     = n;
      i_start     = 1'b1;
      acc_cyc     = cyc;
      @(negedge clk);
      i_start     = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int dc, output logic de, output logic db);
      dc = -1;
      de = 1'bx;
      db = 1'bx;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (o_done === 1'b1) begin
            dc = cyc;
            de = o_err;
            db = o_busy;
            break;
         end
      end
   endtask

   initial begin : main
      string exp5;
      int    fc0;
      int    s0;
      logic  seen;
      CRLF = "\015\012";
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_tx_high", o_uart_tx, 1);
      check("rst_busy_low", o_busy, 0);
      check("rst_done_low", o_done, 0);
      check("rst_err_low", o_err, 0);
      check("rst_rd_addr_zero", o_rd_addr, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 1x1, value 7
      mem[8'h10] = 32'd7;
      clear_mon();
      pulse_start(8'h10, 1, 1);
      check("t1_busy_after_start", o_busy, 1);
      wait_done(4000, dcyc, derr, dbusy);
      check_stream("t1_stream", {"7 ", CRLF});
      check("t1_first_start_within_8", (rx_starts.size() > 0) && (rx_starts[0] - acc_cyc <= 8), 1);
      check("t1_done_after_last_stop", dcyc, last_start() + FRAME);
      check("t1_err_low", derr, 0);
      check("t1_busy_low_at_done", dbusy, 0);
      check("t1_gapless", spacing_ok(), 1);
      check("t1_framing", frame_errs, 0);
      @(negedge clk);
      check("t1_done_single_pulse", o_done, 0);

      // 2x3 at base 0, values 1..6
      for (int i = 0; i < 6; i++) mem[i] = 32'(i + 1);
      clear_mon();
      pulse_start(8'h00, 2, 3);
      wait_done(8000, dcyc, derr, dbusy);
      check_stream("t2_stream", {"1 2 3 ", CRLF, "4 5 6 ", CRLF});
      check("t2_addr_count", addr_q.size(), 6);
      check("t2_addr_seq", (addr_q.size() == 6) && addr_q[0] == 0 && addr_q[1] == 1 &&
            addr_q[2] == 2 && addr_q[3] == 3 && addr_q[4] == 4 && addr_q[5] == 5, 1);
      check("t2_gapless", spacing_ok(), 1);
      check("t2_done_after_last_stop", dcyc, last_start() + FRAME);

      // 1x3 with 8-bit address wrap, values 0, 12345, 100
      mem[8'hFE] = 32'd0;
      mem[8'hFF] = 32'd12345;
      mem[8'h00] = 32'd100;
      clear_mon();
      pulse_start(8'hFE, 1, 3);
      wait_done(8000, dcyc, derr, dbusy);
      check_stream("t3_stream", {"0 12345 100 ", CRLF});
      check("t3_gapless", spacing_ok(), 1);
      check("t3_framing", frame_errs, 0);

      // 1x1, 0xFFF6 with junk in the upper half
      mem[8'h20] = 32'hABCD_FFF6;
`ifdef MTX_SIGNED_EN
      exp5 = {"-10 ", CRLF};
`else
      exp5 = {"65526 ", CRLF};
`endif
      clear_mon();
      pulse_start(8'h20, 1, 1);
      wait_done(8000, dcyc, derr, dbusy);
      check_stream("t4_stream", exp5);
      check("t4_err_low", derr, 0);

      // illegal dimensions: 0x3, then 6x1
      clear_mon();
      fc0 = fall_cnt;
      pulse_start(8'h00, 0, 3);
      wait_done(50, dcyc, derr, dbusy);
      check("t5_done_latency", dcyc - acc_cyc, 2);
      check("t5_err_with_done", derr, 1);
      check("t5_busy_low_at_done", dbusy, 0);
      @(negedge clk);
      check("t5_err_single_pulse", o_err, 0);
      pulse_start(8'h00, 6, 1);
      wait_done(50, dcyc, derr, dbusy);
      check("t5b_done_latency", dcyc - acc_cyc, 2);
      check("t5b_err_with_done", derr, 1);
      repeat (3 * CPB) @(negedge clk);
      check("t5_no_falling_edge", fall_cnt - fc0, 0);
      check("t5_no_bytes", rx_q.size(), 0);

      // reset during the third data bit of '8' (0x38, data bit 2 is 0)
      mem[8'h30] = 32'd8;
      clear_mon();
      pulse_start(8'h30, 1, 1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (o_uart_tx === 1'b0) seen = 1'b1;
         else @(negedge clk);
      end
      check("t6_start_seen", seen, 1);
      s0 = cyc;
      repeat (3 * CPB + CPB / 2) @(negedge clk);
      check("t6_bit2_low", o_uart_tx, 0);
      #1 rst_n = 1'b0;
      #1;
      check("t6_tx_high_in_reset", o_uart_tx, 1);
      check("t6_busy_low_in_reset", o_busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      fc0 = fall_cnt;
      repeat (15 * CPB) @(negedge clk);
      check("t6_no_resume", fall_cnt - fc0, 0);
      check("t6_busy_stays_low", o_busy, 0);
      check("t6_rd_addr_cleared", o_rd_addr, 0);
      if (s0 < 0) $display("unexpected cycle counter");

      // start pulses while busy must not disturb the stream
      mem[8'h40] = 32'd42;
      mem[8'h41] = 32'd9;
      mem[8'h10] = 32'd7;
      clear_mon();
      pulse_start(8'h40, 1, 2);
      repeat (20) @(negedge clk);
      i_base_addr = 8'h10; i_dim_m = 32'd1; i_dim_n = 32'd1; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (300) @(negedge clk);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      wait_done(8000, dcyc, derr, dbusy);
      check_stream("t7_stream", {"42 9 ", CRLF});
      check("t7_done_after_last_stop", dcyc, last_start() + FRAME);
      repeat (40) @(negedge clk);
      check("t7_no_restart_busy", o_busy, 0);
      check("t7_no_extra_bytes", rx_q.size(), 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
